cipher_tx_sequencer: RTL and testbench

- Controller that sequences the XOR cipher datapath over a received message.
- Reads each plaintext byte and its cyclic key byte from the message/key buffers, XORs them, writes the ciphertext to the result buffer and streams it out through the UART sender's Send/Busy handshake.
- Sits between the UART receive/buffer logic (the length registers and the userData/keys/result arrays) and UART_Sender.
- Replaces the free-running encrypt loop with a single, explicitly started, one-pass sequencer.

---
 rtl/cipher_tx_sequencer_if.sv | 35 +++
 rtl/cipher_tx_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_cipher_tx_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cipher_tx_sequencer_if.sv
// rtl/cipher_tx_sequencer_if.sv - buffer and UART sender handshake bundle for cipher_tx_sequencer
//
// Purpose: groups the message/key buffer read ports, the result buffer write
//          port and the UART_Sender Send/Busy handshake into one bundle.
// Signals:
//   Data_Addr / Data_In  message buffer read (Data_In valid 1 cycle after address)
//   Key_Addr  / Key_In   key buffer read (Key_In valid 1 cycle after address)
//   Res_We / Res_Addr / Res_Data   result buffer write port
//   Tx_Data / Tx_Send / Tx_Busy    UART_Sender handshake
// Modports: master = sequencer side, slave = buffers/sender side.

interface cipher_tx_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] Data_Addr;
    logic [7:0]        Data_In;
    logic [ADDR_W-1:0] Key_Addr;
    logic [7:0]        Key_In;
    logic              Res_We;
    logic [ADDR_W-1:0] Res_Addr;
    logic [7:0]        Res_Data;
    logic [7:0]        Tx_Data;
    logic              Tx_Send;
    logic              Tx_Busy;

    modport master (
        output Data_Addr, Key_Addr, Res_We, Res_Addr, Res_Data, Tx_Data, Tx_Send,
        input  Data_In, Key_In, Tx_Busy
    );

    modport slave (
        input  Data_Addr, Key_Addr, Res_We, Res_Addr, Res_Data, Tx_Data, Tx_Send,
        output Data_In, Key_In, Tx_Busy
    );
endinterface

// File: rtl/cipher_tx_sequencer.sv
// rtl/cipher_tx_sequencer.sv - one-pass XOR cipher sequencer feeding UART_Sender
//
// Purpose: on an accepted Start, walks the message buffer once, XORs each byte
//          with the cyclic key byte, writes the ciphertext to the result buffer
//          and transmits it through the UART_Sender Send/Busy handshake.
// Ports:
//   Clk_100M  system clock
//   Reset     synchronous active-high reset
//   Start     level start request, sampled only in IDLE
//   Abort     synchronous return to IDLE (below Reset, above everything else)
//   Data_Len  message length, latched on an accepted Start
//   Key_Len   key length, latched on an accepted Start
//   bus       buffer ports and sender handshake (cipher_tx_sequencer_if.master)
//   Busy      high whenever not IDLE
//   Done      one-cycle pulse after the last frame has left the sender
//   Err       sticky length error, cleared by the next accepted Start
// Optional feature: CIPHER_TX_HEADER_EN - when defined, the latched Data_Len is
//   sent as a header frame before the ciphertext frames.

module cipher_tx_sequencer #(
    parameter int DATA_DEPTH = 100,
    parameter int KEY_DEPTH  = 3,
    parameter int ADDR_W     = 8
) (
    input  logic                  Clk_100M,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Abort,
    input  logic [7:0]            Data_Len,
    input  logic [7:0]            Key_Len,
    cipher_tx_sequencer_if.master bus,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Err
);

    localparam logic [7:0] DATA_MAX = 8'(DATA_DEPTH);
    localparam logic [7:0] KEY_MAX  = 8'(KEY_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_XOR,
        S_SEND,
        S_WAIT_HI,
        S_WAIT_LO,
        S_NEXT,
        S_DONE
    } state_t;

    state_t     state, stateNext;
    logic [7:0] idx, idxNext;
    logic [7:0] kidx, kidxNext;
    logic [7:0] dataLenQ, dataLenNext;
    logic [7:0] keyLenQ, keyLenNext;
    logic [7:0] txData, txDataNext;
    logic       txSend, txSendNext;
    logic       err, errNext;
    logic       resWe;
    logic [7:0] resData;
    logic       doneOut;
    logic       lenBad;
    logic [7:0] cipherByte;
`ifdef CIPHER_TX_HEADER_EN
    // Set while the current SEND/WAIT_HI/WAIT_LO round carries the length header.
    logic       hdrPhase, hdrNext;
`endif

    assign lenBad = (Data_Len == 8'd0) || (Key_Len == 8'd0) ||
                    (Data_Len > DATA_MAX) || (Key_Len > KEY_MAX);
    assign cipherByte = bus.Data_In ^ bus.Key_In;

    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            state    <= S_IDLE;
            idx      <= 8'd0;
            kidx     <= 8'd0;
            dataLenQ <= 8'd0;
            keyLenQ  <= 8'd0;
            txData   <= 8'd0;
            txSend   <= 1'b0;
            err      <= 1'b0;
`ifdef CIPHER_TX_HEADER_EN
            hdrPhase <= 1'b0;
`endif
        end else begin
            state    <= stateNext;
            idx      <= idxNext;
            kidx     <= kidxNext;
            dataLenQ <= dataLenNext;
            keyLenQ  <= keyLenNext;
            txData   <= txDataNext;
            txSend   <= txSendNext;
            err      <= errNext;
`ifdef CIPHER_TX_HEADER_EN
            hdrPhase <= hdrNext;
`endif
        end
    end

    always_comb begin
        stateNext   = state;
        idxNext     = idx;
        kidxNext    = kidx;
        dataLenNext = dataLenQ;
        keyLenNext  = keyLenQ;
        txDataNext  = txData;
        txSendNext  = txSend;
        errNext     = err;
        resWe       = 1'b0;
        resData     = 8'd0;
        doneOut     = 1'b0;
`ifdef CIPHER_TX_HEADER_EN
        hdrNext     = hdrPhase;
`endif
        if (Abort) begin
            // A frame already taken by the sender finishes on its own; no wait here.
            stateNext  = S_IDLE;
            txSendNext = 1'b0;
`ifdef CIPHER_TX_HEADER_EN
            hdrNext    = 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        if (lenBad) begin
                            errNext = 1'b1;
                        end else begin
                            errNext     = 1'b0;
                            dataLenNext = Data_Len;
                            keyLenNext  = Key_Len;
                            idxNext     = 8'd0;
                            kidxNext    = 8'd0;
`ifdef CIPHER_TX_HEADER_EN
                            txDataNext  = Data_Len;
                            hdrNext     = 1'b1;
                            stateNext   = S_SEND;
`else
                            stateNext   = S_RD;
`endif
                        end
                    end
                end
                // Buffer addresses are already idx/kidx; this cycle covers read latency.
                S_RD: stateNext = S_XOR;
                S_XOR: begin
                    resWe      = 1'b1;
                    resData    = cipherByte;
                    txDataNext = cipherByte;
                    stateNext  = S_SEND;
                end
                S_SEND: begin
                    txSendNext = 1'b1;
                    stateNext  = S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (bus.Tx_Busy) begin
                        txSendNext = 1'b0;
                        stateNext  = S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (!bus.Tx_Busy) begin
`ifdef CIPHER_TX_HEADER_EN
                        if (hdrPhase) begin
                            hdrNext   = 1'b0;
                            stateNext = S_RD;
                        end else begin
                            stateNext = S_NEXT;
                        end
`else
                        stateNext = S_NEXT;
`endif
                    end
                end
                S_NEXT: begin
                    if (idx == dataLenQ - 8'd1) begin
                        stateNext = S_DONE;
                    end else begin
                        idxNext   = idx + 8'd1;
                        kidxNext  = (kidx == keyLenQ - 8'd1) ? 8'd0 : kidx + 8'd1;
                        stateNext = S_RD;
                    end
                end
                S_DONE: begin
                    doneOut   = 1'b1;
                    stateNext = S_IDLE;
                end
                default: stateNext = S_IDLE;
            endcase
        end
    end

    assign bus.Data_Addr = ADDR_W'(idx);
    assign bus.Res_Addr  = ADDR_W'(idx);
    assign bus.Key_Addr  = ADDR_W'(kidx);
    assign bus.Res_We    = resWe;
    assign bus.Res_Data  = resData;
    assign bus.Tx_Data   = txData;
    assign bus.Tx_Send   = txSend;
    assign Busy          = (state != S_IDLE);
    assign Done          = doneOut;
    assign Err           = err;

endmodule

// File: tb/tb_cipher_tx_sequencer.sv
// tb/tb_cipher_tx_sequencer.sv - self-checking bench for cipher_tx_sequencer

module tb_cipher_tx_sequencer;

`ifdef CIPHER_TX_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic       Clk_100M = 1'b0;
    logic       Reset    = 1'b1;
    logic       Start    = 1'b0;
    logic       Abort    = 1'b0;
    logic [7:0] Data_Len = 8'd0;
    logic [7:0] Key_Len  = 8'd0;
    logic       Busy, Done, Err;

    cipher_tx_sequencer_if #(.ADDR_W(8)) bus ();

    cipher_tx_sequencer #(.DATA_DEPTH(100), .KEY_DEPTH(3), .ADDR_W(8)) dut (
        .Clk_100M (Clk_100M),
        .Reset    (Reset),
        .Start    (Start),
        .Abort    (Abort),
        .Data_Len (Data_Len),
        .Key_Len  (Key_Len),
        .bus      (bus),
        .Busy     (Busy),
        .Done     (Done),
        .Err      (Err)
    );

    always #5 Clk_100M = ~Clk_100M;

    int nVec = 0;
    int nErr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Buffers with one-cycle read latency.
    logic [7:0] dataMem [256];
    logic [7:0] keyMem  [256];
    always @(posedge Clk_100M) begin
        bus.Data_In <= dataMem[bus.Data_Addr];
        bus.Key_In  <= keyMem[bus.Key_Addr];
    end

    // UART sender: accepts on Send while idle, raises Busy after senderDelay cycles, holds busyLen cycles.
    int senderDelay = 0;
    int busyLen     = 3;
    int sSt, sCnt;
    logic [7:0] txLog [$];
    always @(posedge Clk_100M) begin
        if (Reset) begin
            sSt <= 0;
            sCnt <= 0;
            bus.Tx_Busy <= 1'b0;
        end else begin
            case (sSt)
                0: if (bus.Tx_Send) begin
                    txLog.push_back(bus.Tx_Data);
                    if (senderDelay == 0) begin
                        bus.Tx_Busy <= 1'b1;
                        sCnt <= busyLen - 1;
                        sSt <= 2;
                    end else begin
                        sCnt <= senderDelay - 1;
                        sSt <= 1;
                    end
                end
                1: if (sCnt == 0) begin
                    bus.Tx_Busy <= 1'b1;
                    sCnt <= busyLen - 1;
                    sSt <= 2;
                end else sCnt <= sCnt - 1;
                default: if (sCnt == 0) begin
                    bus.Tx_Busy <= 1'b0;
                    sSt <= 0;
                end else sCnt <= sCnt - 1;
            endcase
        end
    end

    // Observation of result writes and handshake rules, sampled on the falling edge.
    typedef struct { logic [7:0] a; logic [7:0] d; logic [7:0] k; } wr_t;
    wr_t resLog [$];
    wr_t w;
    int busySeen, sendSeen, weCnt, doneCnt, protoViol;
    logic prevSend, prevBusy;
    logic [7:0] prevData;
    always @(negedge Clk_100M) begin
        if (Reset) begin
            prevSend = 1'b0;
            prevBusy = 1'b0;
        end else begin
            if (bus.Res_We) begin
                w.a = bus.Res_Addr; w.d = bus.Res_Data; w.k = bus.Key_Addr;
                resLog.push_back(w);
                weCnt++;
            end
            if (Busy) busySeen++;
            if (bus.Tx_Send) sendSeen++;
            if (Done) doneCnt++;
            if (prevSend && bus.Tx_Send && bus.Tx_Data !== prevData) protoViol++;
            if (prevSend && !bus.Tx_Send && !prevBusy) protoViol++;
            if (prevSend && bus.Tx_Send && prevBusy) protoViol++;
            if (!prevSend && bus.Tx_Send && bus.Tx_Busy) protoViol++;
            prevSend = bus.Tx_Send;
            prevBusy = bus.Tx_Busy;
            prevData = bus.Tx_Data;
        end
    end

    task automatic clearLogs();
        resLog.delete();
        txLog.delete();
        busySeen = 0; sendSeen = 0; weCnt = 0; doneCnt = 0; protoViol = 0;
    endtask

    task automatic randomizeMems();
        for (int i = 0; i < 256; i++) begin
            dataMem[i] = 8'($urandom);
            keyMem[i]  = 8'($urandom);
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_busy"}, Busy, 0);
        check({tag, "_done"}, Done, 0);
        check({tag, "_err"}, Err, 0);
        check({tag, "_res_we"}, bus.Res_We, 0);
        check({tag, "_res_data"}, bus.Res_Data, 0);
        check({tag, "_res_addr"}, bus.Res_Addr, 0);
        check({tag, "_data_addr"}, bus.Data_Addr, 0);
        check({tag, "_key_addr"}, bus.Key_Addr, 0);
        check({tag, "_tx_send"}, bus.Tx_Send, 0);
        check({tag, "_tx_data"}, bus.Tx_Data, 0);
    endtask

    task automatic pulseStart(input logic [7:0] dl, input logic [7:0] kl);
        @(negedge Clk_100M);
        Data_Len = dl;
        Key_Len  = kl;
        Start    = 1'b1;
        @(negedge Clk_100M);
        Start = 1'b0;
    endtask

    // One Start followed by a comparison of everything observed against the cipher rules.
    task automatic runPass(input logic [7:0] dl, input logic [7:0] kl, input logic expErr);
        logic [7:0] expTx [$];
        clearLogs();
        pulseStart(dl, kl);
        if (expErr) begin
            repeat (5) @(negedge Clk_100M);
            check("len_err_set", Err, 1);
            check("len_err_busy", busySeen, 0);
            check("len_err_res_we", weCnt, 0);
            check("len_err_tx_send", sendSeen, 0);
        end else begin
            for (int c = 0; c < 6000 && doneCnt == 0; c++) @(negedge Clk_100M);
            repeat (3) @(negedge Clk_100M);
            check("err_cleared", Err, 0);
            check("done_pulses", doneCnt, 1);
            check("idle_after_done", Busy, 0);
            check("handshake_rules", protoViol, 0);
            check("res_write_count", resLog.size(), 32'(dl));
            for (int i = 0; i < resLog.size() && i < int'(dl); i++) begin
                check($sformatf("res_addr[%0d]", i), resLog[i].a, i);
                check($sformatf("res_data[%0d]", i), resLog[i].d, dataMem[i] ^ keyMem[i % kl]);
                check($sformatf("key_idx[%0d]", i), resLog[i].k, i % kl);
            end
            if (HDR == 1) expTx.push_back(dl);
            for (int i = 0; i < int'(dl); i++) expTx.push_back(dataMem[i] ^ keyMem[i % kl]);
            check("tx_frame_count", txLog.size(), expTx.size());
            for (int i = 0; i < txLog.size() && i < expTx.size(); i++)
                check($sformatf("tx_byte[%0d]", i), txLog[i], expTx[i]);
        end
    endtask

    typedef struct { logic [7:0] dl; logic [7:0] kl; logic expErr; } vec_t;
    vec_t vecs [9];
    logic [7:0] tp1Res [4];
    logic [7:0] tp1Key [4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'd0,   8'd3, 1'b1};
        vecs[1] = '{8'd2,   8'd3, 1'b0};
        vecs[2] = '{8'd2,   8'd4, 1'b1};
        vecs[3] = '{8'd3,   8'd1, 1'b0};
        vecs[4] = '{8'd101, 8'd2, 1'b1};
        vecs[5] = '{8'd100, 8'd3, 1'b0};
        vecs[6] = '{8'd1,   8'd0, 1'b1};
        vecs[7] = '{8'd255, 8'd1, 1'b1};
        vecs[8] = '{8'd7,   8'd2, 1'b0};
        tp1Res = '{8'h51, 8'h62, 8'h73, 8'h54};
        tp1Key = '{8'd0, 8'd1, 8'd2, 8'd0};
        clearLogs();
        randomizeMems();

        repeat (3) @(negedge Clk_100M);
        checkAllZero("reset");
        Reset = 1'b0;

        // Fixed message, long sender frame.
        dataMem[0] = 8'h41; dataMem[1] = 8'h42; dataMem[2] = 8'h43; dataMem[3] = 8'h44;
        keyMem[0] = 8'h10; keyMem[1] = 8'h20; keyMem[2] = 8'h30;
        busyLen = 20;
        runPass(8'd4, 8'd3, 1'b0);
        for (int i = 0; i < resLog.size() && i < 4; i++) begin
            check($sformatf("tp1_res[%0d]", i), resLog[i].d, tp1Res[i]);
            check($sformatf("tp1_kidx[%0d]", i), resLog[i].k, tp1Key[i]);
        end

        // Length table.
        senderDelay = 1; busyLen = 2;
        for (int v = 0; v < 9; v++) begin
            randomizeMems();
            runPass(vecs[v].dl, vecs[v].kl, vecs[v].expErr);
        end

        // Single byte, FF ^ FF.
        dataMem[0] = 8'hFF; keyMem[0] = 8'hFF;
        runPass(8'd1, 8'd1, 1'b0);
        check("single_res_data", resLog.size() > 0 ? resLog[0].d : 8'hXX, 8'h00);

        // Slow sender acceptance: Send held exactly until Busy observed.
        senderDelay = 7; busyLen = 3;
        randomizeMems();
        runPass(8'd3, 8'd2, 1'b0);
        check("send_hold_cycles", sendSeen, (3 + HDR) * (2 + 7));

        // Abort in WAIT_LO of the second byte of five.
        senderDelay = 0; busyLen = 6;
        randomizeMems();
        clearLogs();
        pulseStart(8'd5, 8'd3);
        begin
            int found;
            found = 0;
            for (int c = 0; c < 2000 && found == 0; c++) begin
                @(negedge Clk_100M);
                if (Busy && !bus.Tx_Send && bus.Tx_Busy && bus.Data_Addr == 8'd1 && resLog.size() == 2)
                    found = 1;
            end
            check("abort_point_reached", found, 1);
        end
        Abort = 1'b1;
        @(negedge Clk_100M);
        Abort = 1'b0;
        check("abort_tx_send", bus.Tx_Send, 0);
        check("abort_idle", Busy, 0);
        repeat (5) @(negedge Clk_100M);
        check("abort_no_done", doneCnt, 0);
        check("abort_err_kept", Err, 0);
        for (int c = 0; c < 200 && bus.Tx_Busy; c++) @(negedge Clk_100M);
        runPass(8'd5, 8'd3, 1'b0);

        // Reset in the middle of a pass.
        busyLen = 4;
        clearLogs();
        pulseStart(8'd6, 8'd2);
        repeat (15) @(negedge Clk_100M);
        Reset = 1'b1;
        @(negedge Clk_100M);
        checkAllZero("mid_reset");
        Reset = 1'b0;
        randomizeMems();
        runPass(8'd2, 8'd2, 1'b0);

        // Randomized passes against the cipher rules.
        for (int r = 0; r < 15; r++) begin
            logic [7:0] dl, kl;
            dl = 8'($urandom_range(1, 20));
            kl = 8'($urandom_range(1, 3));
            if ($urandom_range(0, 4) == 0) kl = 8'd4;
            if ($urandom_range(0, 6) == 0) dl = 8'd0;
            senderDelay = $urandom_range(0, 3);
            busyLen = $urandom_range(1, 4);
            randomizeMems();
            runPass(dl, kl, (dl == 0) || (kl == 0) || (dl > 100) || (kl > 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
